// File: rtl/bp_bht_pkg.sv
// Shared types and helpers for the BHT update controller and its tracking FIFO.
// An entry pairs a branch PC with the direction that was predicted for it.
package bp_bht_pkg;

  localparam int unsigned BHT_PC_W = 32;

  typedef struct packed {
    logic [BHT_PC_W-1:0] pc;
    logic                pred;
  } bht_entry_t;

  // Holds at all-ones for a w-bit counter instead of wrapping (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    if (v >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = v + 64'd1;
    end
  endfunction

endpackage

// File: rtl/bp_fifo_sync.sv
// Synchronous FIFO with occupancy count and simultaneous push/pop, also allowed when full.
// The head word is presented combinationally; clr_i empties the FIFO at the next edge.
module bp_fifo_sync #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == (AW+1)'(0));
  assign w_pop   = pop_i & ~w_empty;
  assign w_push  = push_i & (~w_full | w_pop);
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  // Storage array; the head is read before a same-edge write can overwrite it when full.
  always_ff @(posedge clk_i) begin
    if (w_push & ~clr_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else if (clr_i) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bp_bht_update_ctrl.sv
// Issues BHT prediction reads, tracks (PC, prediction) pairs in order, and turns
// in-order backend resolutions into registered BHT training writes plus statistics.
module bp_bht_update_ctrl
  import bp_bht_pkg::*;
#(
  parameter int unsigned PC_W  = BHT_PC_W,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fe_pred_v_i,
  input  logic [PC_W-1:0]  fe_pred_pc_i,
  output logic             fe_pred_ready_o,
  output logic             pred_v_o,
  output logic [PC_W-1:0]  pred_pc_o,
  output logic             pred_taken_o,
  input  logic             res_v_i,
  input  logic             res_taken_i,
  input  logic             flush_i,
  output logic             bht_r_o,
  output logic [PC_W-1:0]  bht_r_pc_o,
  input  logic             bht_predict_i,
  output logic             bht_w_o,
  output logic [PC_W-1:0]  bht_w_pc_o,
  output logic             correct_o,
  output logic             underflow_o,
  output logic [CNT_W-1:0] resolved_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = PC_W + 1;
  localparam logic [AW+1:0] DEPTH_OCC = (AW+2)'(DEPTH);

  logic             r_s1_v;
  logic [PC_W-1:0]  r_s1_pc;
  logic             r_bht_w;
  logic [PC_W-1:0]  r_bht_w_pc;
  logic             r_correct;
  logic             r_underflow;
  logic [CNT_W-1:0] r_resolved_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [AW:0]      w_count;
  logic [AW+1:0]    w_occ;
  logic [EW-1:0]    w_head;
  logic [EW-1:0]    w_push_data;
  logic             w_ready;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_correct;

  // Stage 1 counts toward occupancy because its entry lands in the FIFO next edge.
  assign w_occ       = {1'b0, w_count} + {{(AW+1){1'b0}}, r_s1_v};
  assign w_ready     = ~reset_i & ~flush_i & (w_occ < DEPTH_OCC);
  assign w_accept    = fe_pred_v_i & w_ready;
  assign w_empty     = (w_count == (AW+1)'(0));
  assign w_pop       = res_v_i & ~flush_i & ~w_empty;
  assign w_push      = r_s1_v & ~flush_i;
  assign w_push_data = {r_s1_pc, bht_predict_i};
  assign w_correct   = (w_head[0] == res_taken_i);

  assign fe_pred_ready_o = w_ready;
  assign bht_r_o         = w_accept;
  assign bht_r_pc_o      = w_accept ? fe_pred_pc_i : {PC_W{1'b0}};
  assign pred_v_o        = r_s1_v;
  assign pred_pc_o       = r_s1_v ? r_s1_pc : {PC_W{1'b0}};
  assign pred_taken_o    = r_s1_v & bht_predict_i;
  assign bht_w_o         = r_bht_w;
  assign bht_w_pc_o      = r_bht_w_pc;
  assign correct_o       = r_correct;
  assign underflow_o     = r_underflow;
  assign resolved_cnt_o  = r_resolved_cnt;
  assign mispred_cnt_o   = r_mispred_cnt;

  bp_fifo_sync #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_track_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (flush_i),
    .push_i  (w_push),
    .data_i  (w_push_data),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count)
  );

  // Stage 1 holds the PC whose BHT read is in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1_v  <= 1'b0;
      r_s1_pc <= {PC_W{1'b0}};
    end else if (flush_i) begin
      r_s1_v  <= 1'b0;
      r_s1_pc <= r_s1_pc;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_pc <= fe_pred_pc_i;
      end
    end
  end

  // Training write, statistics and sticky underflow, all registered off the resolve cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_bht_w        <= 1'b0;
      r_bht_w_pc     <= {PC_W{1'b0}};
      r_correct      <= 1'b0;
      r_underflow    <= 1'b0;
      r_resolved_cnt <= {CNT_W{1'b0}};
      r_mispred_cnt  <= {CNT_W{1'b0}};
    end else begin
      r_bht_w <= w_pop;
      if (w_pop) begin
        r_bht_w_pc     <= w_head[EW-1:1];
        r_correct      <= w_correct;
        r_resolved_cnt <= CNT_W'(sat_inc(64'(r_resolved_cnt), CNT_W));
        if (!w_correct) begin
          r_mispred_cnt <= CNT_W'(sat_inc(64'(r_mispred_cnt), CNT_W));
        end
      end else begin
        r_correct <= 1'b0;
      end
      if (res_v_i & ~flush_i & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_bht_update_ctrl.sv
// Randomised and directed bench for bp_bht_update_ctrl, checked every cycle against
// a queue-based model of the outstanding branches.
module tb_bp_bht_update_ctrl;

  localparam int DEP = 8;
  localparam int SAT = 15;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        fe_v;
  logic [31:0] fe_pc;
  logic        fe_pred_ready_o;
  logic        pred_v_o;
  logic [31:0] pred_pc_o;
  logic        pred_taken_o;
  logic        res_v;
  logic        res_t;
  logic        flush;
  logic        bht_r_o;
  logic [31:0] bht_r_pc_o;
  logic        bpred;
  logic        bht_w_o;
  logic [31:0] bht_w_pc_o;
  logic        correct_o;
  logic        underflow_o;
  logic [3:0]  resolved_cnt_o;
  logic [3:0]  mispred_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] pc_q[$];
  bit          pred_q[$];
  bit          m_s1v;
  logic [31:0] m_s1pc;
  bit          m_w;
  logic [31:0] m_wpc;
  bit          m_corr;
  bit          m_under;
  int          m_res;
  int          m_mis;
  bit          m_ready;

  always #5 clk = ~clk;

  bp_bht_update_ctrl #(.PC_W(32), .DEPTH(DEP), .CNT_W(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .fe_pred_v_i     (fe_v),
    .fe_pred_pc_i    (fe_pc),
    .fe_pred_ready_o (fe_pred_ready_o),
    .pred_v_o        (pred_v_o),
    .pred_pc_o       (pred_pc_o),
    .pred_taken_o    (pred_taken_o),
    .res_v_i         (res_v),
    .res_taken_i     (res_t),
    .flush_i         (flush),
    .bht_r_o         (bht_r_o),
    .bht_r_pc_o      (bht_r_pc_o),
    .bht_predict_i   (bpred),
    .bht_w_o         (bht_w_o),
    .bht_w_pc_o      (bht_w_pc_o),
    .correct_o       (correct_o),
    .underflow_o     (underflow_o),
    .resolved_cnt_o  (resolved_cnt_o),
    .mispred_cnt_o   (mispred_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pc_q.delete();
    pred_q.delete();
    m_s1v = 0; m_s1pc = '0; m_w = 0; m_wpc = '0; m_corr = 0;
    m_under = 0; m_res = 0; m_mis = 0;
  endtask

  task automatic model_check();
    m_ready = !flush && ((pc_q.size() + int'(m_s1v)) < DEP);
    chk("ready", fe_pred_ready_o, m_ready);
    chk("bht_r", bht_r_o, fe_v && m_ready);
    if (fe_v && m_ready) chk("bht_r_pc", bht_r_pc_o, fe_pc);
    chk("pred_v", pred_v_o, m_s1v);
    if (m_s1v) begin
      chk("pred_pc", pred_pc_o, m_s1pc);
      chk("pred_taken", pred_taken_o, bpred);
    end
    chk("bht_w", bht_w_o, m_w);
    if (m_w) begin
      chk("bht_w_pc", bht_w_pc_o, m_wpc);
      chk("correct", correct_o, m_corr);
    end
    chk("underflow", underflow_o, m_under);
    chk("resolved_cnt", resolved_cnt_o, m_res);
    chk("mispred_cnt", mispred_cnt_o, m_mis);
  endtask

  // Called at posedge+1: apply inputs, let them settle, compare against the model.
  task automatic drive(input bit fv, input logic [31:0] pc, input bit bp,
                       input bit rv, input bit rt, input bit fl);
    fe_v = fv; fe_pc = pc; bpred = bp; res_v = rv; res_t = rt; flush = fl;
    #3;
    model_check();
  endtask

  task automatic tick();
    bit          acc;
    logic [31:0] hp;
    bit          hpred;
    @(posedge clk);
    acc = fe_v && m_ready;
    m_w = 0;
    if (flush) begin
      pc_q.delete();
      pred_q.delete();
      m_s1v = 0;
    end else begin
      if (res_v) begin
        if (pc_q.size() > 0) begin
          hp = pc_q.pop_front();
          hpred = pred_q.pop_front();
          m_w = 1;
          m_wpc = hp;
          m_corr = (hpred == res_t);
          if (m_res < SAT) m_res++;
          if (!m_corr && m_mis < SAT) m_mis++;
        end else begin
          m_under = 1;
        end
      end
      if (m_s1v) begin
        pc_q.push_back(m_s1pc);
        pred_q.push_back(bpred);
      end
      m_s1v = acc;
      if (acc) m_s1pc = fe_pc;
    end
    #1;
  endtask

  task automatic cyc(input bit fv, input logic [31:0] pc, input bit bp,
                     input bit rv, input bit rt, input bit fl);
    drive(fv, pc, bp, rv, rt, fl);
    tick();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    fe_v = 0; fe_pc = '0; bpred = 0; res_v = 0; res_t = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, fe_pred_ready_o, 0);
    chk({tag, "_bht_r"}, bht_r_o, 0);
    chk({tag, "_pred_v"}, pred_v_o, 0);
    chk({tag, "_bht_w"}, bht_w_o, 0);
    chk({tag, "_bht_w_pc"}, bht_w_pc_o, 0);
    chk({tag, "_underflow"}, underflow_o, 0);
    chk({tag, "_resolved"}, resolved_cnt_o, 0);
    chk({tag, "_mispred"}, mispred_cnt_o, 0);
  endtask

  initial begin
    reset_i = 1'b1;
    fe_v = 0; fe_pc = '0; bpred = 0; res_v = 0; res_t = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset_i = 1'b0;
    model_reset();

    // single flow: accept, predict taken, resolve not-taken four cycles later
    cyc(0, 0, 0, 0, 0, 0);
    drive(1, 32'h104, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    chk("flow_pred_v", pred_v_o, 1);
    chk("flow_pred_taken", pred_taken_o, 1);
    chk("flow_pred_pc", pred_pc_o, 32'h104);
    tick();
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("flow_bht_w", bht_w_o, 1);
    chk("flow_bht_w_pc", bht_w_pc_o, 32'h104);
    chk("flow_correct", correct_o, 0);
    chk("flow_mispred", mispred_cnt_o, 1);
    chk("flow_resolved", resolved_cnt_o, 1);
    tick();

    // fill without resolves, then free one slot
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 32'h1000 + 32'(i * 4), 1'(i), 0, 0, 0);
    drive(1, 32'h2000, 1, 0, 0, 0);
    chk("fill_ready_s1", fe_pred_ready_o, 0);
    tick();
    drive(1, 32'h2000, 0, 0, 0, 0);
    chk("fill_ready_full", fe_pred_ready_o, 0);
    tick();
    cyc(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("fill_ready_back", fe_pred_ready_o, 1);
    chk("fill_w_pc", bht_w_pc_o, 32'h1000);
    tick();

    // push and pop together with 7 stored and stage 1 busy, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 32'h3000 + 32'(i * 4), 1'(i >> 1), 0, 0, 0);
    drive(0, 0, 1, 1, 1, 0);
    chk("conc_ready", fe_pred_ready_o, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("conc_w_pc", bht_w_pc_o, 32'h3000);
    chk("conc_ready_after", fe_pred_ready_o, 1);
    tick();
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 1'($urandom), 0);
    cyc(0, 0, 0, 0, 0, 0);

    // resolution while only stage 1 holds a branch
    do_reset();
    cyc(1, 32'h500, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("uf_bht_w", bht_w_o, 0);
    chk("uf_flag", underflow_o, 1);
    chk("uf_resolved", resolved_cnt_o, 0);
    chk("uf_mispred", mispred_cnt_o, 0);
    tick();
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("uf_sticky", underflow_o, 1);
    tick();

    // flush with five outstanding, concurrent resolve and request
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 32'h700 + 32'(i * 4), 1, 0, 0, 0);
    drive(1, 32'h900, 1, 1, 1, 1);
    chk("fl_ready", fe_pred_ready_o, 0);
    chk("fl_bht_r", bht_r_o, 0);
    chk("fl_pred_v", pred_v_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_no_w", bht_w_o, 0);
    chk("fl_pred_v_after", pred_v_o, 0);
    chk("fl_ready_after", fe_pred_ready_o, 1);
    tick();
    cyc(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_underflow", underflow_o, 1);
    chk("fl_no_w2", bht_w_o, 0);
    tick();

    // counter saturation at 4 bits
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 32'h4000 + 32'(i * 4), 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("sat_resolved", resolved_cnt_o, 15);
    chk("sat_mispred", mispred_cnt_o, 15);
    tick();

    // random traffic with a mid-stream asynchronous reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int rprob;
      rprob = ((i / 200) % 2 == 0) ? 3 : 6;
      cyc(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, 1'($urandom),
          ($urandom % 8) < rprob, 1'($urandom), ($urandom % 64) == 0);
      if (i == 1500) begin
        #2;
        reset_i = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_bht_update_ctrl.md
Name: bp_bht_update_ctrl

Overview:
Front-end controller that initiates all accesses to bp_tournament_bht. It issues prediction reads, records each (PC, prediction) pair in an in-order tracking FIFO, and on in-order branch resolution from the backend drives the BHT write port (bht_w, bht_w_pc, correct). It sits between fetch/PC-gen and the BHT and supplies the feedback that the BHT consumes.

Parameters:
PC_W, 32, PC width
DEPTH, 8, tracking FIFO entries (power of 2, >=2)
CNT_W, 32, width of statistics counters

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high
fe_pred_v_i  in  1  fetch requests a prediction
fe_pred_pc_i  in  PC_W  PC of branch to predict
fe_pred_ready_o  out  1  request accepted this cycle when high
pred_v_o  out  1  prediction result valid
pred_pc_o  out  PC_W  PC of returned prediction
pred_taken_o  out  1  predicted direction
res_v_i  in  1  backend resolves oldest outstanding branch
res_taken_i  in  1  actual direction
flush_i  in  1  discard all outstanding predictions
bht_r_o  out  1  to BHT bht_r_i
bht_r_pc_o  out  PC_W  to BHT bht_r_pc_i
bht_predict_i  in  1  from BHT predict_o, valid the cycle after bht_r_o
bht_w_o  out  1  to BHT bht_w_i
bht_w_pc_o  out  PC_W  to BHT bht_w_pc_i
correct_o  out  1  to BHT correct_i
underflow_o  out  1  sticky: resolution arrived with FIFO empty
resolved_cnt_o  out  CNT_W  branches resolved (saturating)
mispred_cnt_o  out  CNT_W  mispredictions (saturating)

Behaviour:
- Reset: all outputs 0, FIFO empty, stage-1 invalid, counters 0, underflow_o 0. Reset during any operation discards everything immediately.
- fe_pred_ready_o = ~flush_i & ((count + s1_v) < DEPTH), where count = FIFO occupancy and s1_v = the stage-1 valid register.
- Accept (cycle N): fe_pred_v_i & fe_pred_ready_o. bht_r_o is driven combinationally high and bht_r_pc_o = fe_pred_pc_i. At the clock edge, s1_v <= 1 and s1_pc <= pc.
- Cycle N+1 while s1_v is high:
  - pred_v_o = 1, pred_pc_o = s1_pc, pred_taken_o = bht_predict_i (combinational pass-through).
  - {s1_pc, bht_predict_i} is pushed into the FIFO at the end of the cycle.
  - Back-to-back accepts give one read per cycle.
- Resolve (cycle M): res_v_i with count > 0 pops the head. At M+1 these outputs are registered:
  - bht_w_o = 1
  - bht_w_pc_o = head.pc
  - correct_o = (head.pred == res_taken_i)
  - bht_w_o is high for exactly one cycle per resolution.
- An entry is poppable only from the cycle after its push. There is no bypass from stage 1.
- Push and pop in the same cycle are allowed, including at count == DEPTH-1 or DEPTH; occupancy is unchanged.
- res_v_i with count == 0 (no flush): ignored, no BHT write, underflow_o set sticky until reset.
- Counters:
  - resolved_cnt += 1 on each valid pop.
  - mispred_cnt += 1 when correct is 0.
  - Both saturate at 2^CNT_W-1.
- flush_i (cycle F):
  - FIFO and s1_v are cleared at the edge.
  - Same-cycle res_v_i and fe_pred_v_i are ignored, with no counter or underflow effect.
  - A pred_v_o output already showing in F still shows.
  - A BHT write registered from cycle F-1 still issues in F.
- Pointers are log2(DEPTH) bits, and occupancy is log2(DEPTH)+1 bits; wrap-around is natural.
- bht_r_o and bht_w_o may be high in the same cycle (the BHT supports concurrent access).

Decomposition:
- Package bp_bht_pkg: entry typedef {pc[PC_W], pred}, and a saturating-increment function.
- One sub-module, bp_fifo_sync (DEPTH x entry, push/pop/count, simultaneous push+pop). It is reused elsewhere in the front end.

Test Plan:
- Single flow: accept PC 0x104 at cycle 10 with the BHT returning 1 at cycle 11. Resolve taken=0 at cycle 14. Required: pred_v_o/pred_taken_o=1 at cycle 11; bht_w_o=1, bht_w_pc_o=0x104, correct_o=0 at cycle 15; mispred_cnt=1, resolved_cnt=1.
- Fill: DEPTH=8, 8 consecutive accepts with no resolves. Required: fe_pred_ready_o low in the cycle the 8th request is in stage 1 and stays low. After one resolve, ready returns the cycle after the pop.
- Full concurrency: with the FIFO holding 7 entries, s1_v high and res_v_i in the same cycle. Required: occupancy stays 7 → 8−1; write PCs emerge in exact accept order.
- Underflow: res_v_i with the FIFO empty and s1_v high. Required: no bht_w_o, underflow_o=1 and sticky, counters unchanged.
- Flush: 5 outstanding entries, then flush_i together with res_v_i and fe_pred_v_i. Required: ready=0 in the flush cycle, no write from that res, count=0 next cycle, a subsequent res_v_i sets underflow_o.
- Saturation: CNT_W=4, 20 mispredicted resolutions. Required: both counters hold at 15; reset mid-stream zeroes all outputs asynchronously.
